// File: rtl/exec_stage_pipe.sv
// Execute stage: operand select, B pre-shift, ALU with iterative MUL, C and {V,N,Z} status registers.
// Single-cycle ops finish on the accept edge; MUL takes WIDTH edges. Stalls when a result is unconsumed.
module exec_stage_pipe #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 asel,
  input  logic                 bsel,
  input  logic                 loadc,
  input  logic                 loads,
  input  logic [1:0]           shift,
  input  logic [2:0]           alu_op,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     c,
  output logic [2:0]           status,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [WIDTH-1:0]  ain, bsh, bin, bneg, res;
  logic              ovf;
  logic [WIDTH-1:0]  mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]     count;
  logic              ldc, lds;

  always_comb begin
    case (shift)
      2'b01:   bsh = {b[WIDTH-2:0], 1'b0};
      2'b10:   bsh = {1'b0, b[WIDTH-1:1]};
      2'b11:   bsh = {b[WIDTH-1], b[WIDTH-1:1]};
      default: bsh = b;
    endcase
  end

  // The immediate bypasses the shifter entirely.
  assign ain  = asel ? a : '0;
  assign bin  = bsel ? {{(WIDTH-IMM_WIDTH){1'b0}}, imm} : bsh;
  assign bneg = ~bin;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res = ain + bin;
        ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        res = ain + bneg + WIDTH'(1);
        ovf = (ain[WIDTH-1] == bneg[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  res = ain & bin;
      OP_NOT:  res = bneg;
      OP_MUL:  res = '0;
      default: res = bin;
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
    busy      = (state == MUL);
    case (state)
      IDLE: if (in_valid && in_ready && alu_op == OP_MUL) state_nxt = MUL;
      MUL:  if (flush || count == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c         <= '0;
      status    <= '0;
      out_valid <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      ldc       <= 1'b0;
      lds       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      if (alu_op == OP_MUL) begin
        mcand     <= ain;
        mplier    <= bin;
        acc       <= '0;
        count     <= CW'(WIDTH);
        ldc       <= loadc;
        lds       <= loads;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        if (loadc) c <= res;
        if (loads) status <= {ovf, res[WIDTH-1], res == '0};
      end
    end else if (state == MUL) begin
      // Shift-add: consume one multiplier bit per edge, final sum lands on the last one.
      acc    <= acc_nxt;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count - CW'(1);
      if (count == CW'(1)) begin
        out_valid <= 1'b1;
        if (ldc) c <= acc_nxt;
        if (lds) status <= {1'b0, acc_nxt[WIDTH-1], acc_nxt == '0};
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed bench for exec_stage_pipe with hand-computed expectations.
module tb_exec_stage_pipe;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, asel, bsel, loadc, loads;
  logic [1:0]  shift;
  logic [2:0]  alu_op;
  logic [4:0]  imm;
  logic [15:0] a, b, c;
  logic        out_valid, out_ready, busy;
  logic [2:0]  status;
  int          errors = 0;
  int          checks = 0;

  exec_stage_pipe #(.WIDTH(16), .IMM_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .shift(shift), .alu_op(alu_op),
    .imm(imm), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic as, input logic bs, input logic lc,
                        input logic ls, input logic [1:0] sh, input logic [4:0] im,
                        input logic [15:0] av, input logic [15:0] bv);
    alu_op = op; asel = as; bsel = bs; loadc = lc; loads = ls;
    shift = sh; imm = im; a = av; b = bv; in_valid = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    asel = 1'b0; bsel = 1'b0; loadc = 1'b0; loads = 1'b0;
    shift = 2'b00; alu_op = 3'b000; imm = '0; a = '0; b = '0;
    #1 reset_n = 1'b0;
    #20 reset_n = 1'b1;
    step();
    chk("rst_c", c, 0);
    chk("rst_status", status, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);

    // ADD with signed overflow
    set_op(3'b000, 1, 0, 1, 1, 2'b00, 0, 16'h7FFF, 16'h0001);
    step();
    chk("add_c", c, 16'h8000);
    chk("add_status", status, 3'b110);
    chk("add_out_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("add_consumed", out_valid, 0);

    // SUB to zero via immediate, then SUB with loads=0
    set_op(3'b001, 1, 1, 1, 1, 2'b00, 5'd5, 16'h0005, 16'h0009);
    step();
    chk("sub_c", c, 0);
    chk("sub_status", status, 3'b001);
    set_op(3'b001, 1, 1, 1, 0, 2'b00, 5'd2, 16'h0009, 16'h0000);
    step();
    chk("sub_noloads_c", c, 16'h0007);
    chk("sub_noloads_status", status, 3'b001);

    set_op(3'b011, 1, 0, 1, 1, 2'b01, 0, 16'h0000, 16'h00F0);
    step();
    chk("not_lsl_c", c, 16'hFE1F);
    chk("not_lsl_status", status, 3'b010);
    set_op(3'b010, 1, 0, 1, 1, 2'b11, 0, 16'hFFFF, 16'h8000);
    step();
    chk("and_asr_c", c, 16'hC000);
    set_op(3'b010, 1, 0, 1, 1, 2'b10, 0, 16'hFFFF, 16'h8000);
    step();
    chk("and_lsr_c", c, 16'h4000);
    chk("and_lsr_status", status, 3'b000);
    set_op(3'b101, 1, 1, 1, 1, 2'b01, 5'h1F, 16'h1234, 16'hFFFF);
    step();
    chk("mov_imm_unshifted", c, 16'h001F);
    set_op(3'b000, 0, 0, 1, 1, 2'b00, 0, 16'h1111, 16'h0003);
    step();
    chk("add_asel0_c", c, 16'h0003);
    set_op(3'b001, 1, 0, 1, 1, 2'b00, 0, 16'h8000, 16'h0001);
    step();
    chk("sub_ovf_c", c, 16'h7FFF);
    chk("sub_ovf_status", status, 3'b100);
    set_op(3'b000, 1, 0, 0, 1, 2'b00, 0, 16'h0001, 16'h0001);
    step();
    chk("noloadc_c", c, 16'h7FFF);
    chk("noloadc_status", status, 3'b000);
    chk("noloadc_out_valid", out_valid, 1);

    // MUL 3*7: busy for 16 edges, result on edge 16
    set_op(3'b100, 1, 0, 1, 1, 2'b00, 0, 16'h0003, 16'h0007);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      chk("mul_no_valid", out_valid, 0);
      step();
    end
    chk("mul_busy_last", busy, 1);
    step();
    chk("mul_out_valid", out_valid, 1);
    chk("mul_c", c, 16'd21);
    chk("mul_status", status, 3'b000);
    chk("mul_busy_done", busy, 0);

    set_op(3'b100, 1, 0, 1, 1, 2'b00, 0, 16'hFFFF, 16'hFFFF);
    step();
    in_valid = 1'b0;
    repeat (16) step();
    chk("mul_wrap_c", c, 16'h0001);
    chk("mul_wrap_valid", out_valid, 1);

    // Backpressure: held result blocks a second op until out_ready
    set_op(3'b000, 1, 0, 1, 1, 2'b00, 0, 16'h0002, 16'h0003);
    step();
    chk("bp_first_c", c, 16'h0005);
    out_ready = 1'b0;
    set_op(3'b000, 1, 0, 1, 1, 2'b00, 0, 16'h000A, 16'h0014);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    step();
    step();
    chk("bp_c_stable", c, 16'h0005);
    chk("bp_valid_held", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", in_ready, 1);
    step();
    chk("bp_second_c", c, 16'h001E);
    chk("bp_valid_stays", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid, 0);

    // Flush at MUL cycle 8
    set_op(3'b100, 1, 0, 1, 1, 2'b00, 0, 16'h0003, 16'h0005);
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_c", c, 16'h001E);
    chk("flush_status", status, 3'b000);
    repeat (10) step();
    chk("flush_no_late_valid", out_valid, 0);
    chk("flush_c_late", c, 16'h001E);
    flush = 1'b1;
    set_op(3'b000, 1, 0, 1, 1, 2'b00, 0, 16'h0001, 16'h0001);
    #1;
    chk("flush_blocks_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_blocked_c", c, 16'h001E);
    chk("flush_blocked_valid", out_valid, 0);

    // Reset in the middle of a MUL
    set_op(3'b011, 1, 0, 1, 1, 2'b00, 0, 16'h0000, 16'h0000);
    step();
    chk("pre_rst_c", c, 16'hFFFF);
    chk("pre_rst_status", status, 3'b010);
    set_op(3'b100, 1, 0, 1, 1, 2'b00, 0, 16'h0003, 16'h0005);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_c", c, 0);
    chk("mid_rst_status", status, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    #10 reset_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    repeat (20) step();
    chk("post_rst_no_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
